// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator with pixel enable, blanking and start strobes.
// Optional genlock to an external active-low vsync is built when VGA_GENLOCK_EN is defined.
module vga_timing_gen #(
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 56,
  parameter int unsigned H_SYNC     = 120,
  parameter int unsigned H_BP       = 64,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 37,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 23,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             pix_en_in,
`ifdef VGA_GENLOCK_EN
  input  logic             ext_vsync_n_in,
  output logic             locked_out,
`endif
  output logic             h_sync_out,
  output logic             v_sync_out,
  output logic             active_out,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start_out,
  output logic             frame_start_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic             hs_q, hs_d, vs_q, vs_d, act_q, act_d, ls_q, ls_d, fs_q, fs_d;

`ifdef VGA_GENLOCK_EN
  logic sync1_q, sync2_q, sync3_q, pend_q, pend_d, locked_q, locked_d;
  logic fall_c;
`endif

  // Next raster position, then decode every output from that same position
  always_comb begin
    x_nxt = (x_q >= H_MAX) ? '0 : x_q + CNT_W'(1);
    y_nxt = y_q;
    if (x_q >= H_MAX) begin
      y_nxt = (y_q >= V_MAX) ? '0 : y_q + CNT_W'(1);
    end

`ifdef VGA_GENLOCK_EN
    fall_c   = sync3_q & ~sync2_q;
    pend_d   = pend_q | fall_c;
    locked_d = locked_q;
    if (pix_en_in && (pend_q || fall_c)) begin
      pend_d = 1'b0;
      if ((x_nxt == '0) && (y_nxt == V_SS)) begin
        locked_d = 1'b1;
      end else begin
        x_nxt    = '0;
        y_nxt    = V_SS;
        locked_d = 1'b0;
      end
    end
`endif

    x_d   = x_q;
    y_d   = y_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    act_d = act_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (pix_en_in) begin
      x_d   = x_nxt;
      y_d   = y_nxt;
      hs_d  = ((x_nxt >= H_SS) && (x_nxt < H_SE)) ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d  = ((y_nxt >= V_SS) && (y_nxt < V_SE)) ? V_SYNC_POL : ~V_SYNC_POL;
      act_d = (x_nxt < H_ACT) && (y_nxt < V_ACT);
      ls_d  = (x_nxt == '0);
      fs_d  = (x_nxt == '0) && (y_nxt == '0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_q   <= H_MAX;
      y_q   <= V_MAX;
      hs_q  <= ~H_SYNC_POL;
      vs_q  <= ~V_SYNC_POL;
      act_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

`ifdef VGA_GENLOCK_EN
  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      sync3_q  <= 1'b1;
      pend_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      sync1_q  <= ext_vsync_n_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      pend_q   <= pend_d;
      locked_q <= locked_d;
    end
  end

  assign locked_out = locked_q;
`endif

  assign pix_x           = x_q;
  assign pix_y           = y_q;
  assign h_sync_out      = hs_q;
  assign v_sync_out      = vs_q;
  assign active_out      = act_q;
  assign line_start_out  = ls_q;
  assign frame_start_out = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x7 raster: positive- and negative-polarity instances
// checked every cycle against a linear raster-index model.
module tb_vga_timing_gen;

  localparam int CW    = 4;
  localparam int H_TOT = 14;
  localparam int V_TOT = 7;
  localparam int FRAME = H_TOT * V_TOT;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic pix_en_in = 1'b0;

  logic          hs_a, vs_a, act_a, ls_a, fs_a;
  logic [CW-1:0] x_a, y_a;
  logic          hs_b, vs_b, act_b, ls_b, fs_b;
  logic [CW-1:0] x_b, y_b;
`ifdef VGA_GENLOCK_EN
  logic ext_n = 1'b1;
  logic lock_a, lock_b;
`endif

  int passed = 0;
  int total  = 0;

  // Model state: linear raster index p = y*H_TOT + x, 'started' false while in reset state
  bit started = 1'b0;
  int p       = 0;
  bit en_last = 1'b0;

  always #5 clk_in = ~clk_in;

  vga_timing_gen #(
    .CNT_W(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .pix_en_in(pix_en_in),
`ifdef VGA_GENLOCK_EN
    .ext_vsync_n_in(ext_n), .locked_out(lock_a),
`endif
    .h_sync_out(hs_a), .v_sync_out(vs_a), .active_out(act_a),
    .pix_x(x_a), .pix_y(y_a),
    .line_start_out(ls_a), .frame_start_out(fs_a)
  );

  vga_timing_gen #(
    .CNT_W(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .pix_en_in(pix_en_in),
`ifdef VGA_GENLOCK_EN
    .ext_vsync_n_in(ext_n), .locked_out(lock_b),
`endif
    .h_sync_out(hs_b), .v_sync_out(vs_b), .active_out(act_b),
    .pix_x(x_b), .pix_y(y_b),
    .line_start_out(ls_b), .frame_start_out(fs_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Expected outputs derived from the raster index with plain arithmetic
  task automatic check_model();
    int ex, ey;
    bit eact, ehs, evs, els, efs;
    if (!started) begin
      ex = H_TOT - 1; ey = V_TOT - 1;
      eact = 0; ehs = 0; evs = 0; els = 0; efs = 0;
    end else begin
      ex   = p % H_TOT;
      ey   = p / H_TOT;
      eact = (ex < 8) && (ey < 4);
      ehs  = (ex >= 10) && (ex < 12);
      evs  = (ey == 5);
      els  = en_last && (ex == 0);
      efs  = en_last && (p == 0);
    end
    chk("x_a", int'(x_a), ex);     chk("y_a", int'(y_a), ey);
    chk("act_a", int'(act_a), int'(eact));
    chk("hs_a", int'(hs_a), int'(ehs)); chk("vs_a", int'(vs_a), int'(evs));
    chk("ls_a", int'(ls_a), int'(els)); chk("fs_a", int'(fs_a), int'(efs));
    chk("x_b", int'(x_b), ex);     chk("y_b", int'(y_b), ey);
    chk("act_b", int'(act_b), int'(eact));
    chk("hs_b", int'(hs_b), int'(!ehs)); chk("vs_b", int'(vs_b), int'(!evs));
    chk("ls_b", int'(ls_b), int'(els)); chk("fs_b", int'(fs_b), int'(efs));
  endtask

  // One clock: drive enable, advance model on the edge, compare after the falling edge
  task automatic step(input bit en, input bit frc);
    pix_en_in = en;
    @(posedge clk_in);
    if (rst_n_in) begin
      if (en) begin
        if (frc) p = 5 * H_TOT;
        else p = started ? (p + 1) % FRAME : 0;
        started = 1'b1;
      end
      en_last = en;
    end else begin
      started = 1'b0;
      en_last = 1'b0;
    end
    @(negedge clk_in);
    #1;
    check_model();
  endtask

  initial begin
    // Held in reset
    step(0, 0);
    step(1, 0);
    chk("rst_x", int'(x_a), 13);
    chk("rst_y", int'(y_a), 6);
    chk("rst_hs_a", int'(hs_a), 0);
    chk("rst_hs_b", int'(hs_b), 1);
    chk("rst_vs_b", int'(vs_b), 1);
`ifdef VGA_GENLOCK_EN
    chk("rst_lock", int'(lock_a), 0);
`endif
    rst_n_in = 1'b1;

    // First enabled edge lands on (0,0) with both strobes
    step(1, 0);
    chk("first_x", int'(x_a), 0);
    chk("first_y", int'(y_a), 0);
    chk("first_fs", int'(fs_a), 1);
    chk("first_ls", int'(ls_a), 1);
    chk("first_act", int'(act_a), 1);
    step(1, 0);
    chk("second_x", int'(x_a), 1);
    chk("second_ls", int'(ls_a), 0);
    chk("second_fs", int'(fs_a), 0);
    for (int i = 0; i < 7; i++) step(1, 0);
    chk("x8_act", int'(act_a), 0);
    step(1, 0); step(1, 0);
    chk("x10_hs_a", int'(hs_a), 1);
    chk("x10_hs_b", int'(hs_b), 0);
    step(1, 0); step(1, 0);
    chk("x12_hs_a", int'(hs_a), 0);
    step(1, 0); step(1, 0);
    chk("wrap_x", int'(x_a), 0);
    chk("wrap_y", int'(y_a), 1);
    for (int i = 0; i < 83; i++) begin
      step(1, 0);
      if (p == 70) chk("vs_line5", int'(vs_a), 1);
    end
    chk("end_x", int'(x_a), 13);
    chk("end_y", int'(y_a), 6);
    step(1, 0);
    chk("period_fs", int'(fs_a), 1);
    chk("period_x", int'(x_a), 0);

    // Alternating enable
    for (int i = 0; i < 40; i++) step(i % 2 == 0, 0);

    // Random enable
    for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0, 0);

    // Reset mid-frame at (5,2)
    for (int i = 0; i < 200 && !(started && p == 33); i++) step(1, 0);
    chk("reach_5_2", int'(started && p == 33), 1);
    #2 rst_n_in = 1'b0;
    #1;
    started = 1'b0; en_last = 1'b0;
    chk("midrst_x", int'(x_a), 13);
    chk("midrst_y", int'(y_a), 6);
    chk("midrst_act", int'(act_a), 0);
    chk("midrst_hs_b", int'(hs_b), 1);
    check_model();
    step(0, 0); step(1, 0);
    rst_n_in = 1'b1;
    for (int i = 0; i < 200; i++) step($urandom_range(0, 1) != 0, 0);

`ifdef VGA_GENLOCK_EN
    rst_n_in = 1'b0;
    step(0, 0);
    rst_n_in = 1'b1;
    for (int i = 0; i < 200 && !(started && p == 17); i++) step(1, 0);
    chk("reach_3_1", int'(started && p == 17), 1);
    ext_n = 1'b0;
    step(1, 0); step(1, 0); step(1, 1);
    chk("gl_x", int'(x_a), 0);
    chk("gl_y", int'(y_a), 5);
    chk("gl_lock0", int'(lock_a), 0);
    ext_n = 1'b1;
    for (int i = 0; i < 200 && !(p == 67); i++) step(1, 0);
    chk("reach_67", p, 67);
    ext_n = 1'b0;
    step(1, 0); step(1, 0); step(1, 0);
    chk("gl_lock1_a", int'(lock_a), 1);
    chk("gl_lock1_b", int'(lock_b), 1);
    ext_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
